// File: rtl/dc_ipu_mul_unit_pkg.sv
// Shared constants and types for the IPU multiplication unit.
package dc_ipu_mul_unit_pkg;

  // Bit width of one carry-lookahead group inside the adder.
  localparam int CLA_GROUP_W = 4;

  // Sequencer states of the shift-add multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/dc_ipu_mul_unit_carry_lookahead_logic.sv
// 4-bit carry-lookahead block: produces every internal carry of one group
// directly from generate/propagate terms, so no carry ripples inside the group.
module dc_ipu_mul_unit_carry_lookahead_logic (
  input  logic [3:0] gen,
  input  logic [3:0] pro,
  input  logic       c_i,
  output logic [4:0] carry
);

  // Flattened lookahead equations; carry[4] is the group carry-out.
  always_comb begin
    carry[0] = c_i;
    carry[1] = gen[0] | (pro[0] & c_i);
    carry[2] = gen[1] | (pro[1] & gen[0]) | (pro[1] & pro[0] & c_i);
    carry[3] = gen[2] | (pro[2] & gen[1]) | (pro[2] & pro[1] & gen[0])
             | (pro[2] & pro[1] & pro[0] & c_i);
    carry[4] = gen[3] | (pro[3] & gen[2]) | (pro[3] & pro[2] & gen[1])
             | (pro[3] & pro[2] & pro[1] & gen[0])
             | (pro[3] & pro[2] & pro[1] & pro[0] & c_i);
  end

endmodule

// File: rtl/dc_ipu_mul_unit_cla_adder.sv
// WIDTH-bit adder built as a ripple of 4-bit carry-lookahead groups.
module dc_ipu_mul_unit_cla_adder
  import dc_ipu_mul_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum,
  output logic             c_o
);

  localparam int NUM_GROUPS = WIDTH / CLA_GROUP_W;

  // Carry entering each group; the last entry is the adder carry-out.
  logic [NUM_GROUPS:0] group_carry;

  assign group_carry[0] = c_i;
  assign c_o            = group_carry[NUM_GROUPS];

  generate
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
      logic [CLA_GROUP_W-1:0] gen;
      logic [CLA_GROUP_W-1:0] pro;
      logic [CLA_GROUP_W:0]   carry;

      assign gen = a[gi*CLA_GROUP_W +: CLA_GROUP_W] & b[gi*CLA_GROUP_W +: CLA_GROUP_W];
      assign pro = a[gi*CLA_GROUP_W +: CLA_GROUP_W] ^ b[gi*CLA_GROUP_W +: CLA_GROUP_W];

      dc_ipu_mul_unit_carry_lookahead_logic u_cla (
        .gen   (gen),
        .pro   (pro),
        .c_i   (group_carry[gi]),
        .carry (carry)
      );

      assign sum[gi*CLA_GROUP_W +: CLA_GROUP_W] = pro ^ carry[CLA_GROUP_W-1:0];
      assign group_carry[gi+1] = carry[CLA_GROUP_W];
    end
  endgenerate

endmodule

// File: rtl/dc_ipu_mul_unit_seq_multiplier.sv
// Iterative radix-2 shift-add unsigned multiplier (pixel x coefficient).
// One multiply in flight, WIDTH_B iterations, valid/ready on both sides.
module dc_ipu_mul_unit_seq_multiplier
  import dc_ipu_mul_unit_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] product,
  output logic                       busy
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int CW = $clog2(WIDTH_B);

  generate
    if (WIDTH_A % CLA_GROUP_W != 0) begin : g_width_check
      $error("WIDTH_A must be a multiple of the CLA group width");
    end
  endgenerate

  mul_state_t         state_reg;
  mul_state_t         state_next;
  logic [WIDTH_A-1:0] a_reg;
  logic [WIDTH_B-1:0] b_reg;
  logic [PW-1:0]      acc_reg;
  logic [PW-1:0]      acc_next;
  logic [PW-1:0]      product_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH_A-1:0] addend;
  logic [WIDTH_A-1:0] sum_lo;
  logic               sum_carry;
  logic               accept;
  logic               unload;
  logic               last_iter;

  assign accept    = in_valid && (state_reg == IDLE);
  assign unload    = out_ready && (state_reg == DONE);
  assign last_iter = (count_reg == CW'(WIDTH_B - 1));

  // Partial product is the whole multiplicand or nothing, picked by the LSB of the multiplier.
  assign addend = b_reg[0] ? a_reg : '0;

  dc_ipu_mul_unit_cla_adder #(
    .WIDTH (WIDTH_A)
  ) u_adder (
    .a   (acc_reg[PW-1:WIDTH_B]),
    .b   (addend),
    .c_i (1'b0),
    .sum (sum_lo),
    .c_o (sum_carry)
  );

  // Carry-out becomes the new MSB, so the shifted accumulator never loses it.
  assign acc_next = PW'({sum_carry, sum_lo, acc_reg[WIDTH_B-1:0]} >> 1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (unload)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands are captured only on accept, so idle inputs never reach the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        acc_reg   <= '0;
        count_reg <= '0;
      end else if (state_reg == CALC) begin
        acc_reg   <= acc_next;
        b_reg     <= b_reg >> 1;
        count_reg <= count_reg + 1'b1;
        if (last_iter) begin
          product_reg <= acc_next;
        end
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC) || (state_reg == DONE);
  assign product   = product_reg;

endmodule

// File: tb/tb_dc_ipu_mul_unit_seq_multiplier.sv
// Scoreboard bench: stimulus pushes expected products, a monitor pops them on each output handshake.
`timescale 1ns/1ps
module tb_dc_ipu_mul_unit_seq_multiplier;

  localparam int WA = 8;
  localparam int WB = 8;
  localparam int PW = WA + WB;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] a_in;
  logic [WB-1:0] b_in;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  logic [PW-1:0] exp_q[$];
  int            n_cmp;
  int            n_bad;
  longint        last_accept;
  longint        prev_accept;

  dc_ipu_mul_unit_seq_multiplier #(
    .WIDTH_A (WA),
    .WIDTH_B (WB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_output");
      end else begin
        check("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  // Issue one operand pair; returns 1ns after the accept edge.
  task automatic send(input logic [WA-1:0] av, input logic [WB-1:0] bv, input bit keep);
    int w;
    a_in     = av;
    b_in     = bv;
    in_valid = 1'b1;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 1000) begin
        timeout("accept");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    prev_accept = last_accept;
    last_accept = $time;
    exp_q.push_back(PW'(av) * PW'(bv));
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      a_in     = 'x;
      b_in     = 'x;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 2000) timeout("drain");
  endtask

  initial begin
    int k;
    bit done;
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    n_cmp = 0;
    n_bad = 0;
    last_accept = 0;
    prev_accept = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_product", 32'(product), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Max operands and latency
    send(8'd255, 8'd255, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", 32'(k), 8);
    drain();
    check("in_ready_after", 32'(in_ready), 1);

    // Zero operands and unit product
    send(8'd0, 8'd200, 1'b0);
    drain();
    send(8'd37, 8'd0, 1'b0);
    drain();
    send(8'd1, 8'd1, 1'b0);
    drain();

    // Backpressure: result held while downstream stalls
    out_ready = 1'b0;
    send(8'd13, 8'd11, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 50) timeout("bp_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_product", 32'(product), 143);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Back-to-back with in_valid held high
    send(8'd10, 8'd20, 1'b1);
    send(8'd200, 8'd3, 1'b1);
    check("b2b_interval1", 32'((last_accept - prev_accept) / 10), 10);
    send(8'd7, 8'd9, 1'b0);
    check("b2b_interval2", 32'((last_accept - prev_accept) / 10), 10);
    drain();

    // Reset mid-calculation aborts the multiply
    send(8'd100, 8'd100, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_product", 32'(product), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'd2, 8'd3, 1'b0);
    drain();

    // Random operands with random input gaps and output stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          ra = WA'($urandom);
          rb = WB'($urandom);
          send(ra, rb, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
